draw_board_control: RTL and testbench
=====================================

// Module: draw_board_control
// PURPOSE
//   FSM that sequences the board-drawing datapath for one screen refresh.
//   Optionally clears the background, then draws the turn indicator, then all
//     64 cells in x_y_pos order (0..63).
//   For each cell it fetches the cell code from board memory, then asserts
//     write for exactly one cell's worth of pixels, then pulses update_x_y.
//   Sits between the game-logic FSM (start/done handshake) and the datapath/VGA plotter.
// PARAMETERS
//   BG_PIXELS   32768  write cycles for background clear (datapath long_counter span)
//   CELL_PIXELS 256    write cycles per cell / turn indicator (datapath counter span)
//   NUM_CELLS   64     board cells; cell index width is 6
//   MEM_LAT     1      board-memory read latency in cycles (>=1)
// PORTS
//   clk          in   1  system clock, rising edge
//   reset        in   1  asynchronous, active-high reset
//   start        in   1  redraw request; sampled only in IDLE
//   full         in   1  sampled with start: 1 = include background clear
//   hold         in   1  stall: freezes state and counters, forces write=0
//   busy         out  1  high from the cycle after start is accepted until done
//   done         out  1  one-cycle pulse when refresh completes
//   write        out  1  datapath pixel-write enable
//   update_x_y   out  1  one-cycle pulse: datapath advances x_y_pos
//   draw_sel     out  2  00 = cell code from memory, 01 = background, 10 = turn indicator
//   mem_rd_en    out  1  board-memory read strobe
//   mem_addr     out  6  board-memory address = current cell index
// BEHAVIOUR
//   States: IDLE, BG, TURN, FETCH, WAIT, CELL, NEXT, DONE. All outputs are registered.
//   Reset (any time, including mid-refresh):
//     - state=IDLE; pixel count, wait count and cell index = 0
//     - every output = 0
//   IDLE:
//     - start=1 -> BG if full, else TURN; busy=1 from the next cycle
//   BG:
//     - write=1, draw_sel=01 for BG_PIXELS cycles
//     - after the last write, pixel count is cleared and the FSM goes to TURN
//   TURN:
//     - write=1, draw_sel=10 for CELL_PIXELS cycles -> FETCH
//   FETCH:
//     - one cycle: mem_rd_en=1, mem_addr=cell index -> WAIT
//   WAIT:
//     - MEM_LAT cycles, write=0 -> CELL
//     - the memory data is valid when CELL begins
//   CELL:
//     - write=1, draw_sel=00 for CELL_PIXELS cycles -> NEXT
//   NEXT:
//     - one cycle: update_x_y=1, write=0
//     - if cell index = NUM_CELLS-1 -> DONE with index back to 0; else index+1 -> FETCH
//   DONE:
//     - done=1 for one cycle, busy=0 -> IDLE
//   Pixel counter:
//     - counts only on cycles where write=1
//     - the terminal test (count = N-1) is done on a write cycle
//     - exactly N write pulses per phase
//   Datapath wrap alignment:
//     - exactly 256 writes per cell, so the datapath's 8-bit counter wraps back to 0
//     - exactly 64 update_x_y pulses per refresh, so x_y_pos wraps back to 0
//     - 32768 BG writes, so the 15-bit long_counter wraps back to 0
//   hold=1:
//     - write=0, update_x_y=0, mem_rd_en=0
//     - state, counts and index are frozen; the phase resumes unchanged when hold=0
//     - if hold is high in a FETCH or NEXT cycle, that strobe is delayed until hold=0
//   start while busy: ignored, not queued.
//   start and hold both high in IDLE: start is accepted.
//   draw_sel is held stable throughout each phase, including the WAIT/NEXT gaps.
//   Total cycles with hold low:
//     - full=0: 256 + 64*(1+MEM_LAT+256+1) + 1
//     - full=1: the full=0 total + 32768
// TESTING
//   1. Reset -> all outputs 0, IDLE; start=1, full=0 -> first write after 1 cycle,
//      draw_sel=10 for 256 writes, then mem_rd_en with mem_addr=0.
//   2. Full refresh, MEM_LAT=1 -> 32768+256+64*258 write/strobe cycles, exactly 64
//      update_x_y pulses, mem_addr 0..63 in order, a single done pulse, busy low after done.
//   3. hold pulsed for 5 cycles mid-CELL at pixel 100 of cell 7 -> write low for those
//      5 cycles, then writes resume; still 256 writes for cell 7 in total.
//   4. start pulsed while busy (in cell 20) -> no restart; the refresh completes normally
//      with 64 update_x_y pulses.
//   5. reset asserted mid-BG at pixel 1000 -> outputs 0 immediately (async); a later start
//      with full=1 gives the full 32768 BG writes.
//   6. MEM_LAT=3 -> 3 idle cycles between each mem_rd_en and the first CELL write; cell
//      drawing stays 256 write cycles.

Source files
------------

// File: rtl/draw_board_control.sv
// Sequences one screen refresh: optional background clear, turn indicator, then 64 fetch/draw cells.
// Outputs are registered. A hold sampled on a clock edge blanks the strobes and freezes progress for the following cycle.
module draw_board_control #(
  parameter int BG_PIXELS   = 32768,
  parameter int CELL_PIXELS = 256,
  parameter int NUM_CELLS   = 64,
  parameter int MEM_LAT     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       full,
  input  logic       hold,
  output logic       busy,
  output logic       done,
  output logic       write,
  output logic       update_x_y,
  output logic [1:0] draw_sel,
  output logic       mem_rd_en,
  output logic [5:0] mem_addr
);
  localparam int PW = $clog2(BG_PIXELS > CELL_PIXELS ? BG_PIXELS : CELL_PIXELS);
  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [PW-1:0] BG_LAST   = PW'(BG_PIXELS - 1);
  localparam logic [PW-1:0] CELL_LAST = PW'(CELL_PIXELS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_LAT - 1);
  localparam logic [5:0]    IDX_LAST  = 6'(NUM_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BG, S_TURN, S_FETCH, S_WAIT, S_CELL, S_NEXT, S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pix, w_pix_nxt;
  logic [WW-1:0] r_wait, w_wait_nxt;
  logic [5:0]    r_idx, w_idx_nxt;
  // High when the cycle now in progress was not held, i.e. its step really happened.
  logic          r_act;
  logic          r_busy, r_done, r_write, r_upd, r_rd;
  logic [1:0]    r_sel;
  logic          w_busy_nxt, w_done_nxt, w_write_nxt, w_upd_nxt, w_rd_nxt;
  logic [1:0]    w_sel_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_wait  <= '0;
      r_idx   <= '0;
      r_act   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_write <= 1'b0;
      r_upd   <= 1'b0;
      r_rd    <= 1'b0;
      r_sel   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pix   <= w_pix_nxt;
      r_wait  <= w_wait_nxt;
      r_idx   <= w_idx_nxt;
      r_act   <= ~hold;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_write <= w_write_nxt;
      r_upd   <= w_upd_nxt;
      r_rd    <= w_rd_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix;
    w_wait_nxt  = r_wait;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = full ? S_BG : S_TURN;
      S_BG: if (r_act) begin
        if (r_pix == BG_LAST) begin
          w_pix_nxt   = '0;
          w_state_nxt = S_TURN;
        end else begin
          w_pix_nxt = r_pix + 1'b1;
        end
      end
      S_TURN, S_CELL: if (r_act) begin
        if (r_pix == CELL_LAST) begin
          w_pix_nxt   = '0;
          w_state_nxt = (r_state == S_TURN) ? S_FETCH : S_NEXT;
        end else begin
          w_pix_nxt = r_pix + 1'b1;
        end
      end
      S_FETCH: if (r_act) w_state_nxt = S_WAIT;
      S_WAIT: if (r_act) begin
        if (r_wait == WAIT_LAST) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_CELL;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_NEXT: if (r_act) begin
        if (r_idx == IDX_LAST) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs for the coming cycle are decoded from the state being entered.
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_write_nxt = 1'b0;
    w_upd_nxt   = 1'b0;
    w_rd_nxt    = 1'b0;
    w_sel_nxt   = 2'b00;
    unique case (w_state_nxt)
      S_BG: begin
        w_busy_nxt  = 1'b1;
        w_write_nxt = ~hold;
        w_sel_nxt   = 2'b01;
      end
      S_TURN: begin
        w_busy_nxt  = 1'b1;
        w_write_nxt = ~hold;
        w_sel_nxt   = 2'b10;
      end
      S_FETCH: begin
        w_busy_nxt = 1'b1;
        w_rd_nxt   = ~hold;
      end
      S_WAIT:  w_busy_nxt = 1'b1;
      S_CELL: begin
        w_busy_nxt  = 1'b1;
        w_write_nxt = ~hold;
      end
      S_NEXT: begin
        w_busy_nxt = 1'b1;
        w_upd_nxt  = ~hold;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign write      = r_write;
  assign update_x_y = r_upd;
  assign draw_sel   = r_sel;
  assign mem_rd_en  = r_rd;
  assign mem_addr   = r_idx;
endmodule

// File: tb/tb_draw_board_control.sv
// Bench for draw_board_control: two instances (MEM_LAT 1 and 3) share stimulus; each is checked every cycle
// against a refresh-step model. Count checks on the observed traffic pin that model.
module tb_draw_board_control;
  localparam int BG    = 32768;
  localparam int PIX   = 256;
  localparam int CELLS = 64;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       write;
    logic       upd;
    logic [1:0] sel;
    logic       rd;
    logic [5:0] addr;
  } obs_t;

  logic clk = 1'b0;
  logic reset, start, full, hold;
  logic busy0, done0, write0, upd0, rd0, busy1, done1, write1, upd1, rd1;
  logic [1:0] sel0, sel1;
  logic [5:0] addr0, addr1;
  obs_t act0, act1;

  always #5 clk = ~clk;

  draw_board_control #(.MEM_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .full(full), .hold(hold),
    .busy(busy0), .done(done0), .write(write0), .update_x_y(upd0),
    .draw_sel(sel0), .mem_rd_en(rd0), .mem_addr(addr0)
  );
  draw_board_control #(.MEM_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .full(full), .hold(hold),
    .busy(busy1), .done(done1), .write(write1), .update_x_y(upd1),
    .draw_sel(sel1), .mem_rd_en(rd1), .mem_addr(addr1)
  );

  assign act0 = {busy0, done0, write0, upd0, sel0, rd0, addr0};
  assign act1 = {busy1, done1, write1, upd1, sel1, rd1, addr1};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a refresh is a fixed list of steps; step kk is worked out arithmetically.
  int  lat [2] = '{1, 3};
  bit  run [2];
  bit  held [2];
  bit  mfull [2];
  int  k [2];

  function automatic obs_t step_of(int kk, bit f, int l);
    obs_t e   = '0;
    int   per = l + PIX + 2;
    int   c, r;
    e.busy = 1'b1;
    if (f) begin
      if (kk < BG) begin
        e.write = 1'b1;
        e.sel   = 2'b01;
        return e;
      end
      kk -= BG;
    end
    if (kk < PIX) begin
      e.write = 1'b1;
      e.sel   = 2'b10;
      return e;
    end
    kk -= PIX;
    c = kk / per;
    r = kk % per;
    if (c >= CELLS) begin
      e.busy = 1'b0;
      e.done = 1'b1;
      return e;
    end
    if (r == 0) begin
      e.rd   = 1'b1;
      e.addr = 6'(c);
    end else if (r > l && r <= l + PIX) begin
      e.write = 1'b1;
    end else if (r == l + PIX + 1) begin
      e.upd = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t expect_now(int d);
    obs_t e;
    if (!run[d]) return '0;
    e = step_of(k[d], mfull[d], lat[d]);
    if (held[d] && !e.done) begin
      e.write = 1'b0;
      e.upd   = 1'b0;
      e.rd    = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk) begin : model
    obs_t s;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        run[d] = 1'b0;
      end else if (!run[d]) begin
        if (start) begin
          run[d]   = 1'b1;
          k[d]     = 0;
          mfull[d] = full;
          held[d]  = hold;
        end
      end else begin
        s = step_of(k[d], mfull[d], lat[d]);
        if (s.done) begin
          run[d] = 1'b0;
        end else begin
          if (!held[d]) k[d]++;
          held[d] = hold;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    obs_t e, a, m;
    for (int d = 0; d < 2; d++) begin
      e = reset ? obs_t'(0) : expect_now(d);
      a = (d == 0) ? act0 : act1;
      m = '1;
      if (!reset && !e.busy) m.sel = 2'b00;
      if (!reset && !e.rd) m.addr = 6'd0;
      check($sformatf("dut%0d_outputs", d), int'(a & m), int'(e & m));
    end
    if (n_fail > 200) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  // Traffic observers used for the count checks.
  int wr [2][4];
  int upd_n [2], rd_n [2], done_n [2], addr_bad [2], cur_wr [2], c7 [2];
  int gap [2], gmin [2], gmax [2];
  bit gap_run [2];

  task automatic clr_obs();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) wr[d][s] = 0;
      upd_n[d] = 0; rd_n[d] = 0; done_n[d] = 0; addr_bad[d] = 0;
      cur_wr[d] = 0; c7[d] = 0; gap[d] = 0; gmin[d] = 1000; gmax[d] = -1;
      gap_run[d] = 1'b0;
    end
  endtask

  task automatic tick();
    obs_t a;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      a = (d == 0) ? act0 : act1;
      if (a.write) begin
        wr[d][a.sel]++;
        cur_wr[d]++;
      end
      if (gap_run[d]) begin
        if (a.write) begin
          if (gap[d] < gmin[d]) gmin[d] = gap[d];
          if (gap[d] > gmax[d]) gmax[d] = gap[d];
          gap_run[d] = 1'b0;
        end else begin
          gap[d]++;
        end
      end
      if (a.rd) begin
        if (a.addr != 6'(rd_n[d])) addr_bad[d]++;
        rd_n[d]++;
        cur_wr[d]  = 0;
        gap[d]     = 0;
        gap_run[d] = 1'b1;
      end
      if (a.upd) begin
        upd_n[d]++;
        if (rd_n[d] == 8) c7[d] = cur_wr[d];
      end
      if (a.done) done_n[d]++;
    end
  endtask

  task automatic check_counts(string tag, int bg);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_dut%0d_bg_writes", tag, d), wr[d][1], bg);
      check($sformatf("%s_dut%0d_turn_writes", tag, d), wr[d][2], PIX);
      check($sformatf("%s_dut%0d_cell_writes", tag, d), wr[d][0], CELLS * PIX);
      check($sformatf("%s_dut%0d_updates", tag, d), upd_n[d], CELLS);
      check($sformatf("%s_dut%0d_reads", tag, d), rd_n[d], CELLS);
      check($sformatf("%s_dut%0d_addr_order_errs", tag, d), addr_bad[d], 0);
      check($sformatf("%s_dut%0d_done_pulses", tag, d), done_n[d], 1);
    end
  endtask

  initial begin
    int hold_left;
    bit h_used, s_used, resume;
    reset = 1'b1; start = 1'b0; full = 1'b0; hold = 1'b0;
    clr_obs();
    repeat (3) tick();
    check("reset_dut0_outputs", int'(act0), 0);
    check("reset_dut1_outputs", int'(act1), 0);
    reset = 1'b0;
    tick();

    // Refresh 1: no background; hold in cell 7, start while busy in cell 20, random holds later.
    clr_obs();
    hold_left = 0; h_used = 0; s_used = 0; resume = 0;
    start = 1'b1; full = 1'b0;
    tick();
    check("first_write", int'(write0), 1);
    check("first_sel", int'(sel0), 2);
    start = 1'b0;
    for (int i = 0; i < 22000 && !(done_n[0] != 0 && done_n[1] != 0); i++) begin
      tick();
      start = 1'b0;
      if (resume) begin
        check("hold_resume_write", int'(write0), 1);
        resume = 0;
      end
      if (hold_left > 0) begin
        check("hold_write_low", int'(write0), 0);
        hold_left--;
        if (hold_left == 0) begin
          hold   = 1'b0;
          resume = 1;
        end
      end else if (!h_used && rd_n[0] == 8 && cur_wr[0] == 100) begin
        hold = 1'b1; hold_left = 5; h_used = 1;
      end else if (!s_used && rd_n[0] == 21 && cur_wr[0] == 50) begin
        start = 1'b1; full = 1'b1; s_used = 1;
      end else if (rd_n[0] > 30) begin
        hold = ($urandom_range(0, 9) == 0);
        if (rd_n[0] <= 60 && $urandom_range(0, 49) == 0) begin
          start = 1'b1;
          full  = 1'($urandom_range(0, 1));
        end
      end
    end
    hold = 1'b0; start = 1'b0;
    check_counts("r1", 0);
    check("r1_dut0_first_read_was_cell0", addr_bad[0], 0);
    check("r1_cell7_writes", c7[0], PIX);
    repeat (3) tick();
    check("r1_dut0_busy_after_done", int'(busy0), 0);
    check("r1_dut1_busy_after_done", int'(busy1), 0);
    check("r1_dut0_no_restart", done_n[0], 1);

    // Refresh 2: full refresh cut by reset at BG pixel 1000.
    clr_obs();
    start = 1'b1; full = 1'b1;
    tick();
    check("bg_first_sel", int'(sel0), 1);
    start = 1'b0;
    for (int i = 0; i < 1100 && wr[0][1] < 1000; i++) tick();
    check("bg_reached_1000", wr[0][1], 1000);
    #2 reset = 1'b1;
    #1;
    check("async_reset_dut0", int'(act0), 0);
    check("async_reset_dut1", int'(act1), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Refresh 3: complete full refresh, no holds.
    clr_obs();
    start = 1'b1; full = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 52000 && !(done_n[0] != 0 && done_n[1] != 0); i++) tick();
    check_counts("r3", BG);
    check("r3_dut0_total_writes", wr[0][0] + wr[0][1] + wr[0][2], BG + PIX + CELLS * PIX);
    check("r3_dut0_gap_min", gmin[0], 1);
    check("r3_dut0_gap_max", gmax[0], 1);
    check("r3_dut1_gap_min", gmin[1], 3);
    check("r3_dut1_gap_max", gmax[1], 3);
    repeat (3) tick();
    check("r3_dut0_busy_after_done", int'(busy0), 0);
    check("r3_dut1_busy_after_done", int'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
